csa_accum_pipe: RTL and testbench

//  Multi-operand carry-save accumulator with framed streaming input. Each accepted

---
 rtl/csa_accum_pipe.sv | 90 +++++++++
 tb/tb_csa_accum_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_pipe.sv
// csa_accum_pipe: framed multi-operand carry-save accumulator with chunked carry-propagate resolve
module csa_accum_pipe #(
    parameter int BITLEN = 34,
    parameter int NUM_IN = 4,
    parameter int ACCLEN = 40,
    parameter int CHUNK  = 16,
    parameter int SIGNED = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*BITLEN-1:0] in_data,
    input  logic                     in_first,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACCLEN-1:0]        out_data,
    output logic [15:0]              out_beats
);
    localparam int NCHUNK = (ACCLEN + CHUNK - 1) / CHUNK;
    localparam int CW = $clog2(NCHUNK + 1);
    localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, RESOLVE = 2'd2, OUTS = 2'd3;
    logic [1:0] state;
    logic [ACCLEN-1:0] s, t, tree_s, tree_t, res, res_n, x, ps, pt;
    logic [BITLEN-1:0] op;
    logic [CW-1:0] chunk;
    logic cy, cy_n, accept, restart;
    assign in_ready = state == IDLE || state == ACCUM;
    assign accept = in_valid && in_ready;
    assign restart = state == IDLE || in_first;
    assign out_valid = state == OUTS;
    assign out_data = res;
    // t holds the carry vector already doubled (2*C mod 2^ACCLEN); each operand passes one FA row
    always_comb begin
        tree_s = restart ? '0 : s;
        tree_t = restart ? '0 : t;
        op = '0;
        x = '0;
        ps = '0;
        pt = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            op = in_data[k*BITLEN +: BITLEN];
            x = {{(ACCLEN-BITLEN){SIGNED != 0 && op[BITLEN-1]}}, op};
            ps = tree_s;
            pt = tree_t;
            tree_s = ps ^ pt ^ x;
            tree_t = {(ps[ACCLEN-2:0] & pt[ACCLEN-2:0]) | (x[ACCLEN-2:0] & (ps[ACCLEN-2:0] ^ pt[ACCLEN-2:0])), 1'b0};
        end
    end
    always_comb begin
        res_n = res;
        cy_n = cy;
        for (int i = 0; i < ACCLEN; i++) begin
            if (i / CHUNK == int'(chunk)) begin
                res_n[i] = s[i] ^ t[i] ^ cy_n;
                cy_n = (s[i] & t[i]) | (cy_n & (s[i] ^ t[i]));
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s <= '0;
            t <= '0;
            res <= '0;
            out_beats <= '0;
            chunk <= '0;
            cy <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: if (accept) begin
                    s <= tree_s;
                    t <= tree_t;
                    out_beats <= restart ? 16'd1 : out_beats + 16'(out_beats != 16'hFFFF);
                    state <= in_last ? RESOLVE : ACCUM;
                    chunk <= '0;
                    cy <= 1'b0;
                end
                RESOLVE: begin
                    res <= res_n;
                    cy <= cy_n;
                    chunk <= chunk + 1'b1;
                    if (chunk == CW'(NCHUNK - 1)) state <= OUTS;
                end
                default: if (out_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_accum_pipe.sv
// tb_csa_accum_pipe: directed scoreboard bench; u0 unsigned, u1 signed operands
module tb_csa_accum_pipe;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic in_valid [2], in_ready [2], in_first [2], in_last [2], out_valid [2], out_ready [2];
    logic [135:0] in_data [2];
    logic [39:0] out_data [2];
    logic [15:0] out_beats [2];
    logic [55:0] q0 [$], q1 [$];
    logic [55:0] e0, e1;
    int total = 0, passed = 0, n = 0, seen = 0;
    localparam logic [33:0] M1 = '1;

    csa_accum_pipe #(.SIGNED(0)) u0 (
        .clk(clk), .reset(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_first(in_first[0]), .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_beats(out_beats[0]));
    csa_accum_pipe #(.SIGNED(1)) u1 (
        .clk(clk), .reset(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_first(in_first[1]), .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_beats(out_beats[1]));

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid[0] && out_ready[0]) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL out0_extra: got data %0h, expected no result", out_data[0]);
            end else begin
                e0 = q0.pop_front();
                check("out0_data", 64'(out_data[0]), 64'(e0[55:16]));
                check("out0_beats", 64'(out_beats[0]), 64'(e0[15:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid[1] && out_ready[1]) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL out1_extra: got data %0h, expected no result", out_data[1]);
            end else begin
                e1 = q1.pop_front();
                check("out1_data", 64'(out_data[1]), 64'(e1[55:16]));
                check("out1_beats", 64'(out_beats[1]), 64'(e1[15:0]));
            end
        end
    end

    task automatic send(input int d, input logic [33:0] a0, a1, a2, a3, input logic f, l);
        int w = 0;
        in_data[d] = {a3, a2, a1, a0};
        in_first[d] = f;
        in_last[d] = l;
        in_valid[d] = 1'b1;
        @(negedge clk);
        while (!in_ready[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            total++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", w);
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, output int cnt);
        cnt = 0;
        @(negedge clk);
        while (!out_valid[d] && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 40) begin
            total++;
            $display("FAIL out_timeout: got out_valid=0 after %0d cycles, expected 1", cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_first[d] = 1'b0;
            in_last[d] = 1'b0;
            in_data[d] = '0;
            out_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", 64'(in_ready[d]), 64'd1);
            check("rst_out_valid", 64'(out_valid[d]), 64'd0);
            check("rst_out_data", 64'(out_data[d]), 64'd0);
        end
        step();
        rst = 1'b0;
        // one-beat frame and its latency
        q0.push_back({40'd10, 16'd1});
        send(0, 34'd1, 34'd2, 34'd3, 34'd4, 1'b1, 1'b1);
        wait_out(0, n);
        check("t1_latency", 64'(n + 1), 64'd4);
        step();
        // a beat without in_first still opens a frame from IDLE
        q0.push_back({40'd3, 16'd1});
        send(0, 34'd3, 34'd0, 34'd0, 34'd0, 1'b0, 1'b1);
        wait_out(0, n);
        step();
        q0.push_back({40'h2F_FFFF_FFF4, 16'd3});
        for (int i = 0; i < 3; i++) send(0, M1, M1, M1, M1, i == 0, i == 2);
        wait_out(0, n);
        step();
        q0.push_back({40'hFF_FFFF_FF00, 16'd64});
        for (int i = 0; i < 64; i++) send(0, M1, M1, M1, M1, i == 0, i == 63);
        wait_out(0, n);
        step();
        // in_first mid-frame drops the partial sum
        q0.push_back({40'd2, 16'd1});
        send(0, 34'd9, 34'd9, 34'd9, 34'd9, 1'b1, 1'b0);
        send(0, 34'd1, 34'd1, 34'd0, 34'd0, 1'b1, 1'b1);
        wait_out(0, n);
        step();
        // backpressure in OUT
        out_ready[0] = 1'b0;
        q0.push_back({40'd6, 16'd2});
        send(0, 34'd1, 34'd1, 34'd1, 34'd1, 1'b1, 1'b0);
        send(0, 34'd2, 34'd0, 34'd0, 34'd0, 1'b0, 1'b1);
        wait_out(0, n);
        in_data[0] = {34'd0, 34'd0, 34'd0, 34'd9};
        in_first[0] = 1'b1;
        in_last[0] = 1'b1;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 64'(out_valid[0]), 64'd1);
            check("t4_hold_data", 64'(out_data[0]), 64'd6);
            check("t4_in_ready", 64'(in_ready[0]), 64'd0);
            @(negedge clk);
        end
        step();
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_release_ready", 64'(in_ready[0]), 64'd1);
        check("t4_release_valid", 64'(out_valid[0]), 64'd0);
        step();
        // reset during the second RESOLVE cycle drops the frame
        send(0, 34'd1, 34'd1, 34'd1, 34'd1, 1'b1, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1;
        end
        check("t5_no_out", 64'(seen), 64'd0);
        check("t5_in_ready", 64'(in_ready[0]), 64'd1);
        step();
        q0.push_back({40'd5, 16'd1});
        send(0, 34'd5, 34'd0, 34'd0, 34'd0, 1'b1, 1'b1);
        wait_out(0, n);
        step();
        // signed operands
        q1.push_back({40'd7, 16'd1});
        send(1, M1, M1, M1, M1, 1'b1, 1'b0);
        send(1, 34'd7, 34'd0, 34'd0, 34'd0, 1'b1, 1'b1);
        wait_out(1, n);
        step();
        q1.push_back({40'hFF_FFFF_FFFC, 16'd1});
        send(1, M1, M1, M1, M1, 1'b1, 1'b1);
        wait_out(1, n);
        repeat (5) @(negedge clk);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
